// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: scales each FIR band by its pot gain, sums the bands per channel,
// applies volume and saturates, using one shared multiplier sequenced by a small FSM.
module eq_band_mixer #(
    parameter int NUM_CH    = 2,
    parameter int NUM_BANDS = 5,
    parameter int SMPL_W    = 16,
    parameter int POT_W     = 12
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                band_vld,
    output logic                                band_rdy,
    input  logic [NUM_CH*NUM_BANDS*SMPL_W-1:0]  band_smpl,
    input  logic [NUM_BANDS*POT_W-1:0]          band_pot,
    input  logic [POT_W-1:0]                    vol_pot,
    output logic                                out_vld,
    input  logic                                out_rdy,
    output logic [NUM_CH*SMPL_W-1:0]            out_smpl,
    output logic                                busy
);

    localparam int PROD_W = SMPL_W + POT_W + 1;
    localparam int ACC_W  = SMPL_W + POT_W + 1 + $clog2(NUM_BANDS) + 1;
    localparam int BCNT_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int CCNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SH     = POT_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_VOL, S_OUT} state_t;

    state_t                             r_state;
    state_t                             w_state_next;

    logic [NUM_CH*NUM_BANDS*SMPL_W-1:0] r_smpl;
    logic [NUM_BANDS*POT_W-1:0]         r_pot;
    logic [POT_W-1:0]                   r_vol;
    logic signed [ACC_W-1:0]            r_acc;
    logic [BCNT_W-1:0]                  r_band_cnt;
    logic [CCNT_W-1:0]                  r_ch_cnt;
    logic                               r_out_vld;
    logic signed [SMPL_W-1:0]           r_out [NUM_CH];

    logic signed [SMPL_W-1:0]           w_smpl [NUM_CH][NUM_BANDS];
    logic [POT_W-1:0]                   w_pot  [NUM_BANDS];
    logic                               w_last_band;
    logic                               w_last_ch;
    logic signed [SMPL_W-1:0]           w_mul_a;
    logic signed [POT_W:0]              w_mul_b;
    logic signed [PROD_W-1:0]           w_prod;
    logic signed [ACC_W-1:0]            w_prod_ext;
    logic signed [ACC_W-1:0]            w_acc_sh;
    logic signed [ACC_W-1:0]            w_vol_sh;
    logic signed [SMPL_W-1:0]           w_sat_acc;
    logic signed [SMPL_W-1:0]           w_sat_vol;

    // Clamp to the signed SMPL_W range: in range iff all bits above the sample sign bit agree.
    function automatic logic signed [SMPL_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-SMPL_W:0] top;
        top = v[ACC_W-1:SMPL_W-1];
        if ((&top) || (~|top))
            return v[SMPL_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(SMPL_W-1){1'b0}}};
        else
            return {1'b0, {(SMPL_W-1){1'b1}}};
    endfunction

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            for (gj = 0; gj < NUM_BANDS; gj++) begin : g_band
                assign w_smpl[gi][gj] = r_smpl[(gi*NUM_BANDS+gj)*SMPL_W +: SMPL_W];
            end
            assign out_smpl[gi*SMPL_W +: SMPL_W] = r_out[gi];
        end
        for (gi = 0; gi < NUM_BANDS; gi++) begin : g_pot
            assign w_pot[gi] = r_pot[gi*POT_W +: POT_W];
        end
    endgenerate

    assign w_last_band = (r_band_cnt == BCNT_W'(NUM_BANDS - 1));
    assign w_last_ch   = (r_ch_cnt == CCNT_W'(NUM_CH - 1));

    // Single multiplier: band sample x band gain while accumulating, level x volume otherwise.
    always_comb begin
        w_mul_a = w_sat_acc;
        w_mul_b = {1'b0, r_vol};
        if (r_state == S_MAC) begin
            w_mul_a = w_smpl[r_ch_cnt][r_band_cnt];
            w_mul_b = {1'b0, w_pot[r_band_cnt]};
        end
    end

    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_sh   = r_acc >>> SH;
    assign w_sat_acc  = sat(w_acc_sh);
    assign w_vol_sh   = w_prod_ext >>> SH;
    assign w_sat_vol  = sat(w_vol_sh);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (band_vld)    w_state_next = S_MAC;
            S_MAC:  if (w_last_band) w_state_next = S_VOL;
            S_VOL:  w_state_next = w_last_ch ? S_OUT : S_MAC;
            S_OUT:  if (out_rdy)     w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        band_rdy = (r_state == S_IDLE);
        busy     = (r_state != S_IDLE);
    end

    assign out_vld = r_out_vld;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_smpl     <= '0;
            r_pot      <= '0;
            r_vol      <= '0;
            r_acc      <= '0;
            r_band_cnt <= '0;
            r_ch_cnt   <= '0;
            r_out_vld  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                r_out[c] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc      <= '0;
                    r_band_cnt <= '0;
                    r_ch_cnt   <= '0;
                    if (band_vld) begin
                        r_smpl <= band_smpl;
                        r_pot  <= band_pot;
                        r_vol  <= vol_pot;
                    end
                end
                S_MAC: begin
                    r_acc      <= r_acc + w_prod_ext;
                    r_band_cnt <= w_last_band ? '0 : r_band_cnt + BCNT_W'(1);
                end
                S_VOL: begin
                    r_out[r_ch_cnt] <= w_sat_vol;
                    r_acc           <= '0;
                    r_ch_cnt        <= w_last_ch ? '0 : r_ch_cnt + CCNT_W'(1);
                    if (w_last_ch)
                        r_out_vld <= 1'b1;
                end
                S_OUT: begin
                    if (out_rdy)
                        r_out_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Bench for eq_band_mixer: table of vectors with hand-derived results, a few random vectors
// against a reference calculation, and sequences for latency, backpressure and mid-run reset.
module tb_eq_band_mixer;

    localparam int NC = 2;
    localparam int NB = 5;
    localparam int SW = 16;
    localparam int PW = 12;

    logic                   clk;
    logic                   rst_n;
    logic                   band_vld;
    logic                   band_rdy;
    logic [NC*NB*SW-1:0]    band_smpl;
    logic [NB*PW-1:0]       band_pot;
    logic [PW-1:0]          vol_pot;
    logic                   out_vld;
    logic                   out_rdy;
    logic [NC*SW-1:0]       out_smpl;
    logic                   busy;

    eq_band_mixer #(.NUM_CH(NC), .NUM_BANDS(NB), .SMPL_W(SW), .POT_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .band_vld  (band_vld),
        .band_rdy  (band_rdy),
        .band_smpl (band_smpl),
        .band_pot  (band_pot),
        .vol_pot   (vol_pot),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_smpl  (out_smpl),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NC*NB*SW-1:0]    smpl;
        logic [NB*PW-1:0]       pot;
        logic [PW-1:0]          vol;
        logic signed [SW-1:0]   e0;
        logic signed [SW-1:0]   e1;
    } vec_t;

    typedef struct {
        logic signed [SW-1:0]   e0;
        logic signed [SW-1:0]   e1;
        int                     id;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic vec_t mk(input int a0, input int a1, input int p, input int v,
                                input int e0, input int e1);
        vec_t t;
        for (int b = 0; b < NB; b++) begin
            t.smpl[b*SW +: SW]      = SW'(a0);
            t.smpl[(NB+b)*SW +: SW] = SW'(a1);
            t.pot[b*PW +: PW]       = PW'(p);
        end
        t.vol = PW'(v);
        t.e0  = SW'(e0);
        t.e1  = SW'(e1);
        return t;
    endfunction

    function automatic longint clamp(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference: exact integer sum, floor division by 2^(PW-1), clamp, then the same for volume.
    function automatic vec_t with_model(input vec_t t);
        vec_t   r;
        longint acc;
        longint s;
        longint o [NC];
        r = t;
        for (int c = 0; c < NC; c++) begin
            acc = 0;
            for (int b = 0; b < NB; b++)
                acc += longint'($signed(t.smpl[(c*NB+b)*SW +: SW])) * longint'(t.pot[b*PW +: PW]);
            s    = clamp(acc >>> (PW-1));
            o[c] = clamp((s * longint'(t.vol)) >>> (PW-1));
        end
        r.e0 = SW'(o[0]);
        r.e1 = SW'(o[1]);
        return r;
    endfunction

    // Output side of the scoreboard: every accepted output is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n && out_vld && out_rdy) begin
                if (sb.size() == 0) begin
                    timeout("unexpected output");
                end else begin
                    e = sb.pop_front();
                    $display("txn %0d: ch0=%0d ch1=%0d (want %0d %0d)", e.id,
                             $signed(out_smpl[SW-1:0]), $signed(out_smpl[2*SW-1:SW]), e.e0, e.e1);
                    chk($sformatf("txn%0d ch0", e.id), $signed(out_smpl[SW-1:0]), e.e0);
                    chk($sformatf("txn%0d ch1", e.id), $signed(out_smpl[2*SW-1:SW]), e.e1);
                end
            end
        end
    end

    task automatic push_exp(input vec_t t, input int id);
        exp_t e;
        e.e0 = t.e0;
        e.e1 = t.e1;
        e.id = id;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input vec_t t, input int id);
        int k = 0;
        while (!band_rdy && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!band_rdy) begin
            timeout("band_rdy wait");
            return;
        end
        band_smpl = t.smpl;
        band_pot  = t.pot;
        vol_pot   = t.vol;
        band_vld  = 1'b1;
        push_exp(t, id);
        @(posedge clk); #1;
        band_vld  = 1'b0;
        // Scramble the inputs: only the captured values may influence the result.
        band_smpl = {$urandom, $urandom, $urandom, $urandom, $urandom};
        band_pot  = {$urandom, $urandom};
        vol_pot   = PW'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            timeout("drain");
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        t;
        int          n;
        int          seen;
        logic [31:0] hold;

        tbl[0] = mk(  1000,   1000, 2048, 2048,   5000,   5000);
        tbl[1] = mk(  1000,   1000,    0, 2048,      0,      0);
        tbl[2] = mk(  1000,   1000, 2048, 1024,   2500,   2500);
        tbl[3] = mk(     0,      0, 2048, 2048,     -3,     -3);
        tbl[3].smpl[2*SW +: SW]      = 16'hFFFD;
        tbl[3].smpl[(NB+2)*SW +: SW] = 16'hFFFD;
        tbl[4] = mk( 20000,  20000, 4095, 4095,  32767,  32767);
        tbl[5] = mk(-20000, -20000, 4095, 4095, -32768, -32768);
        tbl[6] = mk(  1000,  -1000, 2048, 2048,   5000,  -5000);
        tbl[7] = mk( 20000, -20000, 2048,    0,      0,      0);
        tbl[8] = mk(-32768, -32768, 2048, 2048, -32768, -32768);
        tbl[9] = mk(     0,      0,    0, 2048,   1999,   1999);
        tbl[9].smpl[0 +: SW]      = 16'd1000;
        tbl[9].smpl[NB*SW +: SW]  = 16'd1000;
        tbl[9].pot[0 +: PW]       = 12'd4095;

        rst_n     = 1'b1;
        band_vld  = 1'b0;
        band_smpl = '0;
        band_pot  = '0;
        vol_pot   = '0;
        out_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset band_rdy", band_rdy, 1);
        chk("reset out_vld", out_vld, 0);
        chk("reset out_smpl", out_smpl, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // Latency: handshake is cycle 0, out_vld must first be seen in cycle 13.
        band_smpl = tbl[0].smpl;
        band_pot  = tbl[0].pot;
        vol_pot   = tbl[0].vol;
        band_vld  = 1'b1;
        push_exp(tbl[0], 0);
        @(posedge clk); #1;
        band_vld = 1'b0;
        n = 1;
        chk("busy band_rdy", band_rdy, 0);
        chk("busy flag", busy, 1);
        while (!out_vld && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 13);
        @(posedge clk); #1;
        chk("idle after accept band_rdy", band_rdy, 1);
        chk("idle after accept out_vld", out_vld, 0);
        drain();

        for (int i = 0; i < 10; i++)
            send(tbl[i], 10 + i);
        drain();

        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < NC*NB; s++)
                t.smpl[s*SW +: SW] = SW'($urandom_range(0, 65535));
            for (int b = 0; b < NB; b++)
                t.pot[b*PW +: PW] = PW'($urandom_range(0, 4095));
            t.vol = PW'($urandom_range(0, 4095));
            t = with_model(t);
            send(t, 30 + i);
        end
        drain();

        // Backpressure: output held for 10 cycles, a band_vld pulse in the window is ignored.
        out_rdy = 1'b0;
        send(tbl[6], 40);
        n = 0;
        while (!out_vld && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_vld) timeout("backpressure out_vld");
        hold = out_smpl;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                band_smpl = tbl[4].smpl;
                band_pot  = tbl[4].pot;
                vol_pot   = tbl[4].vol;
                band_vld  = 1'b1;
            end else begin
                band_vld  = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("hold%0d out_smpl", i), out_smpl, hold);
            chk($sformatf("hold%0d band_rdy", i), band_rdy, 0);
            chk($sformatf("hold%0d out_vld", i), out_vld, 1);
        end
        band_vld = 1'b0;
        out_rdy  = 1'b1;
        @(posedge clk); #1;
        chk("release band_rdy", band_rdy, 1);
        chk("release out_vld", out_vld, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_vld || busy) seen++;
        end
        chk("ignored pulse activity", seen, 0);

        // Reset during cycle 5 of a transaction aborts it asynchronously.
        send(tbl[0], 50);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        #1;
        chk("abort out_vld", out_vld, 0);
        chk("abort out_smpl", out_smpl, 0);
        chk("abort band_rdy", band_rdy, 1);
        chk("abort busy", busy, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        send(tbl[0], 51);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
